// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcode encodings, functional-unit FSM states and the
// tagged result record broadcast on the common data bus.
package tomasulo_pkg;

  localparam int RES_DATA_W = 16;
  localparam int RES_TAG_W  = 3;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_SD  = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } fu_state_e;

  // Default-width record used by reservation stations and the CDB arbiter.
  typedef struct packed {
    logic [RES_TAG_W-1:0]  tag;
    logic [RES_DATA_W-1:0] data;
    logic                  err;
  } fu_result_t;

endpackage

// File: rtl/tomasulo_exec_unit_if.sv
// Issue and CDB handshake bundle between a reservation station / CDB arbiter (master)
// and a functional unit (slave).
interface tomasulo_exec_unit_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int OPC_W  = 4
);
  logic              issue_valid;
  logic              issue_ready;
  logic [OPC_W-1:0]  issue_op;
  logic [TAG_W-1:0]  issue_tag;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;
  logic              cdb_valid;
  logic              cdb_grant;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_err;

  modport master (
    output issue_valid, issue_op, issue_tag, issue_a, issue_b, cdb_grant,
    input  issue_ready, cdb_valid, cdb_tag, cdb_data, cdb_err
  );

  modport slave (
    input  issue_valid, issue_op, issue_tag, issue_a, issue_b, cdb_grant,
    output issue_ready, cdb_valid, cdb_tag, cdb_data, cdb_err
  );
endinterface

// File: rtl/fu_result_fifo.sv
// Shift-style result FIFO: slot 0 is always the registered head, so the head outputs
// stay glitch-free and stable until popped. Vacated slots are zeroed.
module fu_result_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       head_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    wr_idx;
  logic             do_pop;
  logic [WIDTH-1:0] slot_q [DEPTH];

  // A grant against an empty queue is ignored.
  assign do_pop = pop && (count_reg != '0);
  assign wr_idx = do_pop ? (count_reg - CW'(1)) : count_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [WIDTH-1:0] slot_reg;
    logic [WIDTH-1:0] shift_in;

    if (gi < DEPTH - 1) begin : g_mid
      assign shift_in = slot_q[gi+1];
    end else begin : g_last
      assign shift_in = '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        slot_reg <= '0;
      end else if (clear) begin
        slot_reg <= '0;
      end else if (push && (wr_idx == CW'(gi))) begin
        slot_reg <= push_data;
      end else if (do_pop) begin
        slot_reg <= shift_in;
      end
    end

    assign slot_q[gi] = slot_reg;
  end

  assign head_data  = slot_q[0];
  assign head_valid = (count_reg != '0);
  assign count      = count_reg;

  no_write_when_full: assert property (@(posedge clock) disable iff (!resetn)
    !(push && !clear && !do_pop && (count_reg == CW'(DEPTH))));

endmodule

// File: rtl/tomasulo_exec_unit.sv
// Tomasulo functional unit: registers one issued op, executes it with an opcode-dependent
// latency and queues the tagged result for CDB broadcast under arbiter grant.
module tomasulo_exec_unit
  import tomasulo_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int TAG_W     = 3,
  parameter int OPC_W     = 4,
  parameter int ALU_LAT   = 1,
  parameter int MUL_LAT   = 3,
  parameter int RES_DEPTH = 2
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           flush,
  tomasulo_exec_unit_if.slave            bus,
  output logic                           busy,
  output logic [$clog2(RES_DEPTH+1)-1:0] occupancy
);
  localparam int OCC_W   = $clog2(RES_DEPTH + 1);
  localparam int MAX_LAT = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              err;
  } result_t;

  fu_state_e         state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              busy_reg;
  logic [OPC_W-1:0]  op_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;

  logic              issue_ready;
  logic              issue_fire;
  int                issue_lat;
  logic              complete;
  logic              push;
  logic [DATA_W-1:0] res_data;
  logic              res_err;
  result_t           push_rec;
  result_t           head_rec;
  logic              head_valid;
  logic [OCC_W-1:0]  occ;

  assign issue_ready = (state_reg == ST_IDLE) && (occ < OCC_W'(RES_DEPTH));
  assign issue_fire  = bus.issue_valid && issue_ready;
  assign issue_lat   = (bus.issue_op == OPC_W'(OP_MUL)) ? MUL_LAT : ALU_LAT;
  assign complete    = (state_reg == ST_EXEC) && (cnt_reg == '0);
  assign push        = complete && !flush;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      op_reg    <= '0;
      tag_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else if (flush) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (issue_fire) begin
            state_reg <= ST_EXEC;
            cnt_reg   <= CNT_W'(issue_lat - 1);
            busy_reg  <= 1'b1;
            op_reg    <= bus.issue_op;
            tag_reg   <= bus.issue_tag;
            a_reg     <= bus.issue_a;
            b_reg     <= bus.issue_b;
          end
        end
        ST_EXEC: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Result is formed from the held operands on the completing cycle only.
  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (op_reg)
      OPC_W'(OP_ADD): res_data = a_reg + b_reg;
      OPC_W'(OP_SUB): res_data = a_reg - b_reg;
      OPC_W'(OP_MUL): res_data = a_reg * b_reg;
      OPC_W'(OP_AND): res_data = a_reg & b_reg;
      OPC_W'(OP_OR):  res_data = a_reg | b_reg;
      OPC_W'(OP_SLT): res_data = DATA_W'($signed(a_reg) < $signed(b_reg));
      OPC_W'(OP_LD), OPC_W'(OP_SD): res_err = 1'b1;
      default:        res_err = 1'b1;
    endcase
  end

  assign push_rec = '{tag: tag_reg, data: res_data, err: res_err};

  fu_result_fifo #(
    .WIDTH ($bits(result_t)),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .clear      (flush),
    .push       (push),
    .push_data  (push_rec),
    .pop        (bus.cdb_grant),
    .head_data  (head_rec),
    .head_valid (head_valid),
    .count      (occ)
  );

  assign bus.issue_ready = issue_ready;
  assign bus.cdb_valid   = head_valid;
  assign bus.cdb_tag     = head_rec.tag;
  assign bus.cdb_data    = head_rec.data;
  assign bus.cdb_err     = head_rec.err;
  assign busy            = busy_reg;
  assign occupancy       = occ;

endmodule
